// File: rtl/mmio_req_router_if.sv
// Bus bundle between the CPU data side, the memory wrapper and the MMIO device port.
// The slave modport is the router's view; master is the surrounding environment.
interface mmio_req_router_if;
  // CPU request and read response
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  // Memory wrapper request and response
  logic [31:0] mem_Address;
  logic        mem_MemWrite;
  logic [31:0] mem_Write_data;
  logic [3:0]  mem_Write_strb;
  logic        mem_MemRead;
  logic        mem_Mem_Req_Ready;
  logic [31:0] mem_Read_data;
  logic        mem_Read_data_Valid;
  logic        mem_Read_data_Ready;
  // MMIO device request and response
  logic        dev_req_valid;
  logic        dev_req_ready;
  logic        dev_we;
  logic [3:0]  dev_off;
  logic [31:0] dev_wdata;
  logic [3:0]  dev_wstrb;
  logic [31:0] dev_rdata;
  logic        dev_rvalid;
  logic        dev_rready;

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    output mem_Address, mem_MemWrite, mem_Write_data, mem_Write_strb, mem_MemRead,
    output mem_Read_data_Ready,
    input  mem_Mem_Req_Ready, mem_Read_data, mem_Read_data_Valid,
    output dev_req_valid, dev_we, dev_off, dev_wdata, dev_wstrb, dev_rready,
    input  dev_req_ready, dev_rdata, dev_rvalid
  );

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    input  mem_Address, mem_MemWrite, mem_Write_data, mem_Write_strb, mem_MemRead,
    input  mem_Read_data_Ready,
    output mem_Mem_Req_Ready, mem_Read_data, mem_Read_data_Valid,
    input  dev_req_valid, dev_we, dev_off, dev_wdata, dev_wstrb, dev_rready,
    output dev_req_ready, dev_rdata, dev_rvalid
  );
endinterface

// File: rtl/mmio_req_router.sv
// MMIO request router: steers CPU data-side requests to the memory wrapper or the
// device port by Address[31:16], keeps one read in flight, buffers device read data
// and substitutes ERR_DATA when a device read goes unanswered for TIMEOUT cycles.
module mmio_req_router #(
  parameter logic [15:0] DEV_BASE = 16'h6000,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                cpu_clk,
  input  logic                cpu_reset,
  mmio_req_router_if.slave    bus,
  output logic [7:0]          timeout_cnt
);

  // Wait counter only has to reach TIMEOUT-1; the FSM leaves DEV_RD there.
  localparam int unsigned       WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_DEV_RD = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [31:0]       r_buf;
  logic [WAIT_W-1:0] r_wait;
  logic [7:0]        r_tmo_cnt;

  logic w_is_dev;
  logic w_idle;
  logic w_mem_rd_hs;
  logic w_dev_rd_hs;

  // Address decode and read-handshake detection in IDLE.
  always_comb begin
    w_is_dev    = (bus.Address[31:16] == DEV_BASE);
    w_idle      = (r_state == ST_IDLE);
    w_mem_rd_hs = w_idle & bus.MemRead & ~w_is_dev & bus.mem_Mem_Req_Ready;
    w_dev_rd_hs = w_idle & bus.MemRead &  w_is_dev & bus.dev_req_ready;
  end

  // Request forwarding: combinational passthrough in IDLE, all request strobes gated off otherwise.
  always_comb begin
    bus.mem_Address    = bus.Address;
    bus.mem_Write_data = bus.Write_data;
    bus.mem_Write_strb = bus.Write_strb;
    bus.dev_off        = bus.Address[3:0];
    bus.dev_wdata      = bus.Write_data;
    bus.dev_wstrb      = bus.Write_strb;
    // A combined read+write is a read; the device sees dev_we low.
    bus.dev_we         = ~bus.MemRead;
    if (w_idle) begin
      bus.mem_MemRead   = bus.MemRead & ~w_is_dev;
      bus.mem_MemWrite  = bus.MemWrite & ~bus.MemRead & ~w_is_dev;
      bus.dev_req_valid = (bus.MemRead | bus.MemWrite) & w_is_dev;
      bus.Mem_Req_Ready = w_is_dev ? bus.dev_req_ready : bus.mem_Mem_Req_Ready;
    end else begin
      bus.mem_MemRead   = 1'b0;
      bus.mem_MemWrite  = 1'b0;
      bus.dev_req_valid = 1'b0;
      bus.Mem_Req_Ready = 1'b0;
    end
  end

  // Response path: memory data passes straight through, device data comes from the buffer.
  always_comb begin
    bus.Read_data           = r_buf;
    bus.Read_data_Valid     = 1'b0;
    bus.mem_Read_data_Ready = 1'b0;
    bus.dev_rready          = 1'b0;
    case (r_state)
      ST_MEM_RD: begin
        bus.Read_data           = bus.mem_Read_data;
        bus.Read_data_Valid     = bus.mem_Read_data_Valid;
        bus.mem_Read_data_Ready = bus.Read_data_Ready;
      end
      ST_DEV_RD: begin
        bus.dev_rready = 1'b1;
      end
      ST_RESP: begin
        bus.Read_data_Valid = 1'b1;
      end
      default: begin
        bus.Read_data_Valid = 1'b0;
      end
    endcase
  end

  // Read FSM with response buffer, device wait counter and saturating timeout counter.
  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      r_state   <= ST_IDLE;
      r_buf     <= 32'h0000_0000;
      r_wait    <= '0;
      r_tmo_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_rd_hs) begin
            r_state <= ST_MEM_RD;
          end else if (w_dev_rd_hs) begin
            r_state <= ST_DEV_RD;
            r_wait  <= '0;
          end
        end
        ST_MEM_RD: begin
          if (bus.mem_Read_data_Valid & bus.Read_data_Ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DEV_RD: begin
          r_wait <= r_wait + WAIT_W'(1);
          // Device data wins over a timeout landing in the same cycle.
          if (bus.dev_rvalid) begin
            r_buf   <= bus.dev_rdata;
            r_state <= ST_RESP;
          end else if (r_wait == WAIT_LAST) begin
            r_buf   <= ERR_DATA;
            r_state <= ST_RESP;
            if (r_tmo_cnt != 8'hFF) begin
              r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (bus.Read_data_Ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign timeout_cnt = r_tmo_cnt;

endmodule

// File: tb/tb_mmio_req_router.sv
// Self-checking bench for mmio_req_router: directed scenarios plus a randomized
// transaction mix checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mmio_req_router;

  localparam int unsigned TMO = 64;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic       clk;
  logic       rst;
  logic [7:0] tcnt;

  mmio_req_router_if bus();

  mmio_req_router #(.DEV_BASE(16'h6000), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .cpu_clk     (clk),
    .cpu_reset   (rst),
    .bus         (bus),
    .timeout_cnt (tcnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_tmo  = 0;

  // Reference memory (what the CPU wrote) and the responder's backing store (what the wrapper saw).
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] back_mem  [logic [31:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.Address = 32'h0; bus.MemWrite = 1'b0; bus.Write_data = 32'h0; bus.Write_strb = 4'h0;
    bus.MemRead = 1'b0; bus.Read_data_Ready = 1'b0; bus.mem_Mem_Req_Ready = 1'b0;
    bus.mem_Read_data = 32'h0; bus.mem_Read_data_Valid = 1'b0; bus.dev_req_ready = 1'b0;
    bus.dev_rdata = 32'h0; bus.dev_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step(); mid();
    if ({bus.Read_data_Valid, bus.dev_rready, bus.mem_Read_data_Ready, bus.mem_MemRead,
         bus.mem_MemWrite, bus.dev_req_valid, bus.Mem_Req_Ready} !== 7'b0) begin
      $display("FAIL reset_outputs: got %b expected 0000000", {bus.Read_data_Valid, bus.dev_rready,
               bus.mem_Read_data_Ready, bus.mem_MemRead, bus.mem_MemWrite, bus.dev_req_valid, bus.Mem_Req_Ready});
      n_fail++;
    end
    n_checks++;
    if (tcnt !== 8'd0) begin $display("FAIL reset_tcnt: got %0d expected 0", tcnt); n_fail++; end
    n_checks++;
    if (bus.Read_data !== 32'h0) begin $display("FAIL reset_buf: got %h expected 0", bus.Read_data); n_fail++; end
    n_checks++;
    step();
    rst = 1'b0;
    exp_tmo = 0;
  endtask

  task automatic test_mem_write_read();
    bus.Address = 32'h0000_0100; bus.MemWrite = 1'b1; bus.Write_data = 32'h1234_5678;
    bus.Write_strb = 4'hF; bus.mem_Mem_Req_Ready = 1'b1; bus.dev_req_ready = 1'b1;
    mid();
    if ({bus.mem_MemWrite, bus.mem_MemRead, bus.dev_req_valid, bus.Mem_Req_Ready} !== 4'b1001 ||
        bus.mem_Address !== 32'h100 || bus.mem_Write_data !== 32'h1234_5678 || bus.mem_Write_strb !== 4'hF) begin
      $display("FAIL memwr_fwd: got w%b r%b dv%b rdy%b a=%h d=%h expected w1 r0 dv0 rdy1 a=100 d=12345678",
               bus.mem_MemWrite, bus.mem_MemRead, bus.dev_req_valid, bus.Mem_Req_Ready, bus.mem_Address, bus.mem_Write_data);
      n_fail++;
    end
    n_checks++;
    if (bus.mem_MemWrite && bus.mem_Mem_Req_Ready) back_mem[bus.mem_Address] = bus.mem_Write_data;
    step();
    bus.MemWrite = 1'b0; bus.MemRead = 1'b1;
    mid();
    if ({bus.mem_MemRead, bus.mem_MemWrite, bus.dev_req_valid, bus.Mem_Req_Ready} !== 4'b1001) begin
      $display("FAIL memrd_fwd: got r%b w%b dv%b rdy%b expected r1 w0 dv0 rdy1",
               bus.mem_MemRead, bus.mem_MemWrite, bus.dev_req_valid, bus.Mem_Req_Ready);
      n_fail++;
    end
    n_checks++;
    step();
    bus.Address = 32'h0000_0200;
    mid();
    if ({bus.mem_MemRead, bus.Mem_Req_Ready, bus.Read_data_Valid} !== 3'b000) begin
      $display("FAIL memrd_busy: got r%b rdy%b v%b expected 000", bus.mem_MemRead, bus.Mem_Req_Ready, bus.Read_data_Valid);
      n_fail++;
    end
    n_checks++;
    step();
    bus.MemRead = 1'b0; bus.mem_Read_data_Valid = 1'b1; bus.Read_data_Ready = 1'b1;
    bus.mem_Read_data = back_mem.exists(32'h100) ? back_mem[32'h100] : 32'h0;
    mid();
    if (bus.Read_data !== 32'h1234_5678 || bus.Read_data_Valid !== 1'b1 || bus.mem_Read_data_Ready !== 1'b1) begin
      $display("FAIL memrd_resp: got d=%h v=%b rr=%b expected d=12345678 v=1 rr=1",
               bus.Read_data, bus.Read_data_Valid, bus.mem_Read_data_Ready);
      n_fail++;
    end
    n_checks++;
    step();
    idle_inputs(); bus.mem_Mem_Req_Ready = 1'b1;
    mid();
    if (bus.Mem_Req_Ready !== 1'b1) begin $display("FAIL memrd_idle: got rdy=%b expected 1", bus.Mem_Req_Ready); n_fail++; end
    n_checks++;
    ref_mem[32'h100] = 32'h1234_5678;
    step();
    idle_inputs();
  endtask

  task automatic test_dev_write_stall();
    bus.Address = 32'h6000_0004; bus.MemWrite = 1'b1; bus.Write_data = 32'h41; bus.Write_strb = 4'hF;
    bus.dev_req_ready = 1'b0; bus.mem_Mem_Req_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dev_req_ready = 1'b1;
      mid();
      if ({bus.dev_req_valid, bus.dev_we, bus.mem_MemWrite} !== 3'b110 || bus.dev_off !== 4'h4 ||
          bus.dev_wdata !== 32'h41 || bus.Mem_Req_Ready !== (i == 3)) begin
        $display("FAIL devwr_cyc%0d: got dv%b we%b mw%b off=%h wd=%h rdy=%b expected dv1 we1 mw0 off=4 wd=41 rdy=%b",
                 i, bus.dev_req_valid, bus.dev_we, bus.mem_MemWrite, bus.dev_off, bus.dev_wdata, bus.Mem_Req_Ready, (i == 3));
        n_fail++;
      end
      n_checks++;
      step();
    end
    idle_inputs();
    mid();
    if ({bus.dev_req_valid, bus.dev_rready} !== 2'b00) begin
      $display("FAIL devwr_after: got dv%b rr%b expected 00", bus.dev_req_valid, bus.dev_rready);
      n_fail++;
    end
    n_checks++;
    step();
  endtask

  task automatic test_dev_read();
    bus.Address = 32'h6000_0008; bus.MemRead = 1'b1; bus.dev_req_ready = 1'b1;
    mid();
    if ({bus.dev_req_valid, bus.dev_we, bus.mem_MemRead, bus.Mem_Req_Ready} !== 4'b1001 || bus.dev_off !== 4'h8) begin
      $display("FAIL devrd_req: got dv%b we%b mr%b rdy%b off=%h expected dv1 we0 mr0 rdy1 off=8",
               bus.dev_req_valid, bus.dev_we, bus.mem_MemRead, bus.Mem_Req_Ready, bus.dev_off);
      n_fail++;
    end
    n_checks++;
    step();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) begin bus.dev_rvalid = 1'b1; bus.dev_rdata = 32'h1; end
      mid();
      if ({bus.dev_rready, bus.Read_data_Valid} !== 2'b10) begin
        $display("FAIL devrd_wait%0d: got rr%b v%b expected rr1 v0", k, bus.dev_rready, bus.Read_data_Valid);
        n_fail++;
      end
      n_checks++;
      step();
    end
    bus.dev_rvalid = 1'b0; bus.dev_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) bus.Read_data_Ready = 1'b1;
      mid();
      if (bus.Read_data !== 32'h1 || bus.Read_data_Valid !== 1'b1 || bus.dev_rready !== 1'b0) begin
        $display("FAIL devrd_hold%0d: got d=%h v=%b rr=%b expected d=1 v=1 rr=0", k, bus.Read_data, bus.Read_data_Valid, bus.dev_rready);
        n_fail++;
      end
      n_checks++;
      step();
    end
    idle_inputs();
    mid();
    if (bus.Read_data_Valid !== 1'b0) begin $display("FAIL devrd_idle: got v=%b expected 0", bus.Read_data_Valid); n_fail++; end
    n_checks++;
    step();
  endtask

  task automatic test_dev_timeout();
    logic [31:0] late_data;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: device silent; pass 1: data arrives in the timeout cycle and wins
      late_data = 32'hCAFE_0001;
      bus.Address = 32'h6000_000C; bus.MemRead = 1'b1; bus.dev_req_ready = 1'b1;
      step();
      idle_inputs();
      for (int k = 1; k <= int'(TMO); k++) begin
        if (pass == 1 && k == int'(TMO)) begin bus.dev_rvalid = 1'b1; bus.dev_rdata = late_data; end
        step();
        bus.dev_rvalid = 1'b0;
        mid();
        if (bus.Read_data_Valid !== (k >= int'(TMO))) begin
          $display("FAIL tmo%0d_valid_k%0d: got v=%b expected %b", pass, k, bus.Read_data_Valid, (k >= int'(TMO)));
          n_fail++;
        end
        n_checks++;
      end
      if (pass == 0) exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
      if (bus.Read_data !== ((pass == 0) ? ERR : late_data) || tcnt !== 8'(exp_tmo)) begin
        $display("FAIL tmo%0d_data: got d=%h cnt=%0d expected d=%h cnt=%0d", pass, bus.Read_data, tcnt,
                 (pass == 0) ? ERR : late_data, exp_tmo);
        n_fail++;
      end
      n_checks++;
      step();
      bus.Read_data_Ready = 1'b1;
      step();
      idle_inputs();
      if (pass == 0) begin
        bus.dev_rvalid = 1'b1; bus.dev_rdata = 32'h55;
        for (int k = 0; k < 3; k++) begin
          mid();
          if ({bus.dev_rready, bus.Read_data_Valid} !== 2'b00 || tcnt !== 8'(exp_tmo)) begin
            $display("FAIL tmo_late%0d: got rr%b v%b cnt=%0d expected 00 cnt=%0d", k, bus.dev_rready, bus.Read_data_Valid, tcnt, exp_tmo);
            n_fail++;
          end
          n_checks++;
          step();
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    d = $urandom;
    bus.Address = 32'h6000_0008; bus.MemRead = 1'b1; bus.MemWrite = 1'b1; bus.Write_data = 32'hFFFF_0000;
    bus.dev_req_ready = 1'b1; bus.mem_Mem_Req_Ready = 1'b1;
    mid();
    if ({bus.dev_req_valid, bus.dev_we, bus.mem_MemWrite, bus.mem_MemRead} !== 4'b1000) begin
      $display("FAIL conflict_req: got dv%b we%b mw%b mr%b expected 1000", bus.dev_req_valid, bus.dev_we, bus.mem_MemWrite, bus.mem_MemRead);
      n_fail++;
    end
    n_checks++;
    step();
    mid();
    if ({bus.Mem_Req_Ready, bus.dev_req_valid, bus.dev_rready} !== 3'b001) begin
      $display("FAIL conflict_busy: got rdy%b dv%b rr%b expected 001", bus.Mem_Req_Ready, bus.dev_req_valid, bus.dev_rready);
      n_fail++;
    end
    n_checks++;
    step();
    idle_inputs();
    bus.dev_rvalid = 1'b1; bus.dev_rdata = d;
    step();
    bus.dev_rvalid = 1'b0; bus.Read_data_Ready = 1'b1;
    mid();
    if (bus.Read_data !== d || bus.Read_data_Valid !== 1'b1) begin
      $display("FAIL conflict_resp: got d=%h v=%b expected d=%h v=1", bus.Read_data, bus.Read_data_Valid, d);
      n_fail++;
    end
    n_checks++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_mid_reset();
    bus.Address = 32'h6000_0000; bus.MemRead = 1'b1; bus.dev_req_ready = 1'b1;
    step();
    idle_inputs();
    mid();
    if (bus.dev_rready !== 1'b1) begin $display("FAIL rst_devrd_pre: got rr=%b expected 1", bus.dev_rready); n_fail++; end
    n_checks++;
    #1 rst = 1'b1;
    #1;
    exp_tmo = 0;
    if ({bus.dev_rready, bus.Read_data_Valid} !== 2'b00 || tcnt !== 8'd0) begin
      $display("FAIL rst_devrd: got rr%b v%b cnt=%0d expected 00 cnt=0", bus.dev_rready, bus.Read_data_Valid, tcnt);
      n_fail++;
    end
    n_checks++;
    step();
    rst = 1'b0;
    bus.Address = 32'h0000_0100; bus.MemRead = 1'b1; bus.mem_Mem_Req_Ready = 1'b1;
    step();
    idle_inputs();
    bus.mem_Read_data_Valid = 1'b1; bus.mem_Read_data = 32'h77; bus.Read_data_Ready = 1'b1;
    mid();
    if (bus.Read_data_Valid !== 1'b1) begin $display("FAIL rst_memrd_pre: got v=%b expected 1", bus.Read_data_Valid); n_fail++; end
    n_checks++;
    #1 rst = 1'b1;
    #1;
    if ({bus.Read_data_Valid, bus.mem_Read_data_Ready} !== 2'b00 || bus.Read_data !== 32'h0) begin
      $display("FAIL rst_memrd: got v%b rr%b d=%h expected 00 d=0", bus.Read_data_Valid, bus.mem_Read_data_Ready, bus.Read_data);
      n_fail++;
    end
    n_checks++;
    step();
    rst = 1'b0;
    idle_inputs();
    bus.Address = 32'h0000_0100; bus.MemRead = 1'b1; bus.mem_Mem_Req_Ready = 1'b1;
    step();
    idle_inputs();
    step();
    bus.mem_Read_data_Valid = 1'b1; bus.Read_data_Ready = 1'b1;
    bus.mem_Read_data = back_mem.exists(32'h100) ? back_mem[32'h100] : 32'h0;
    mid();
    if (bus.Read_data !== ref_mem[32'h100] || bus.Read_data_Valid !== 1'b1) begin
      $display("FAIL rst_fresh_rd: got d=%h v=%b expected d=%h v=1", bus.Read_data, bus.Read_data_Valid, ref_mem[32'h100]);
      n_fail++;
    end
    n_checks++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    int unsigned op, stall, dly, hold;
    logic        is_rd, is_dev;
    logic [31:0] a, wd, dd, exp_d, lat_a;
    int          e;
    for (int t = 0; t < 40; t++) begin
      op     = $urandom_range(0, 3);
      is_rd  = op[0];
      is_dev = op[1];
      a      = is_dev ? {16'h6000, 16'($urandom)} : (32'h0001_0000 | (32'($urandom_range(0, 7)) << 2));
      wd     = $urandom;
      stall  = $urandom_range(0, 2);
      bus.Address = a; bus.MemRead = is_rd; bus.MemWrite = ~is_rd; bus.Write_data = wd; bus.Write_strb = 4'hF;
      for (int c = 0; c <= int'(stall); c++) begin
        if (is_dev) begin bus.dev_req_ready = (c == int'(stall)); bus.mem_Mem_Req_Ready = 1'($urandom); end
        else begin bus.mem_Mem_Req_Ready = (c == int'(stall)); bus.dev_req_ready = 1'($urandom); end
        mid();
        if (bus.Mem_Req_Ready !== (c == int'(stall)) ||
            {bus.mem_MemRead, bus.mem_MemWrite, bus.dev_req_valid} !== (is_dev ? 3'b001 : {is_rd, ~is_rd, 1'b0}) ||
            (is_dev && (bus.dev_we !== ~is_rd || bus.dev_off !== a[3:0] || bus.dev_wdata !== wd)) ||
            (!is_dev && (bus.mem_Address !== a || bus.mem_Write_data !== wd))) begin
          $display("FAIL rnd%0d_req: op=%0d rdy=%b mr%b mw%b dv%b we%b", t, op, bus.Mem_Req_Ready,
                   bus.mem_MemRead, bus.mem_MemWrite, bus.dev_req_valid, bus.dev_we);
          n_fail++;
        end
        n_checks++;
        lat_a = bus.mem_Address;
        if (c == int'(stall) && !is_dev && !is_rd) back_mem[bus.mem_Address] = bus.mem_Write_data;
        step();
      end
      idle_inputs();
      if (!is_dev && !is_rd) ref_mem[a] = wd;
      if (is_rd && !is_dev) begin
        dly = $urandom_range(0, 3);
        for (int j = 0; j < int'(dly); j++) begin
          mid();
          if (bus.Read_data_Valid !== 1'b0) begin $display("FAIL rnd%0d_mwait: got v=%b expected 0", t, bus.Read_data_Valid); n_fail++; end
          n_checks++;
          step();
        end
        exp_d = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        bus.mem_Read_data_Valid = 1'b1; bus.Read_data_Ready = 1'b1;
        bus.mem_Read_data = back_mem.exists(lat_a) ? back_mem[lat_a] : 32'h0;
        mid();
        if (bus.Read_data !== exp_d || bus.Read_data_Valid !== 1'b1) begin
          $display("FAIL rnd%0d_mresp: got d=%h v=%b expected d=%h v=1", t, bus.Read_data, bus.Read_data_Valid, exp_d);
          n_fail++;
        end
        n_checks++;
        step();
        idle_inputs();
      end else if (is_rd && is_dev) begin
        dly   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TMO);
        dd    = $urandom;
        e     = (dly == 0) ? int'(TMO) : int'(dly);
        exp_d = (dly == 0) ? ERR : dd;
        if (dly == 0) exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
        for (int j = 1; j <= e; j++) begin
          if (j == int'(dly)) begin bus.dev_rvalid = 1'b1; bus.dev_rdata = dd; end
          step();
          bus.dev_rvalid = 1'b0;
          mid();
          if (bus.Read_data_Valid !== (j == e)) begin
            $display("FAIL rnd%0d_dwait%0d: got v=%b expected %b", t, j, bus.Read_data_Valid, (j == e));
            n_fail++;
          end
          n_checks++;
        end
        hold = $urandom_range(0, 2);
        for (int h = 0; h <= int'(hold); h++) begin
          if (h > 0) mid();
          if (bus.Read_data !== exp_d || bus.Read_data_Valid !== 1'b1 || tcnt !== 8'(exp_tmo)) begin
            $display("FAIL rnd%0d_dresp: got d=%h v=%b cnt=%0d expected d=%h v=1 cnt=%0d", t, bus.Read_data,
                     bus.Read_data_Valid, tcnt, exp_d, exp_tmo);
            n_fail++;
          end
          n_checks++;
          step();
          bus.Read_data_Ready = (h + 1 == int'(hold));
        end
        if (hold == 0) begin
          bus.Read_data_Ready = 1'b1;
          step();
        end
        idle_inputs();
      end
    end
    mid();
    if (tcnt !== 8'(exp_tmo)) begin $display("FAIL rnd_tcnt: got %0d expected %0d", tcnt, exp_tmo); n_fail++; end
    n_checks++;
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mem_write_read();
    test_dev_write_stall();
    test_dev_read();
    test_dev_timeout();
    test_conflict();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
